apb_req_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer sitting in front of the APB master bridge.
- Serialises read and write commands from two internal sources (requester 0 = UART command path, requester 1 = GPIO command path) onto the bridge's single command interface.
- Drives transfer, READ_WRITE, PSEL and the addresses and write data; waits for access completion and returns read data, ack and error to the granted requester.
- Includes a watchdog so that a stalled slave cannot lock the bus.

---
 rtl/apb_req_arbiter_pkg.sv | 17 +
 rtl/apb_req_arbiter_if.sv | 38 +++
 rtl/apb_req_arbiter_rr_arb2.sv | 21 ++
 rtl/apb_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and constants for the APB request arbiter.
// The FSM state enum, the READ_WRITE encoding and the default watchdog limit.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    RESP
  } arb_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Command interface between the request arbiter (master) and the APB master bridge (slave).
interface apb_req_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              transfer;
  logic              READ_WRITE;
  logic              PSEL;
  logic [ADDR_W-1:0] apb_write_paddr;
  logic [ADDR_W-1:0] apb_read_paddr;
  logic [DATA_W-1:0] apb_write_data;
  logic              bridge_done;
  logic [DATA_W-1:0] bridge_rdata;

  modport master (
    output transfer,
    output READ_WRITE,
    output PSEL,
    output apb_write_paddr,
    output apb_read_paddr,
    output apb_write_data,
    input  bridge_done,
    input  bridge_rdata
  );

  modport slave (
    input  transfer,
    input  READ_WRITE,
    input  PSEL,
    input  apb_write_paddr,
    input  apb_read_paddr,
    input  apb_write_data,
    output bridge_done,
    output bridge_rdata
  );

endinterface

// File: rtl/apb_req_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on contention the requester
// that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter/sequencer serialising two requesters onto the APB bridge
// command interface, with a watchdog that aborts stalled accesses.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  apb_req_arbiter_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_t        state, state_nxt;
  logic              last_grant;
  logic              grant_idx;
  logic              pick_idx;
  logic              pick_vld;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  wd_cnt;
  logic              wd_expired;

  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));

  rr_arb2 u_rr_arb2 (
    .req        ({req1, req0}),
    .last_grant (last_grant),
    .grant      (pick_idx),
    .valid      (pick_vld)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_vld) state_nxt = SETUP;
      SETUP: state_nxt = WAIT;
      WAIT:  if (bus.bridge_done || wd_expired) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      last_grant          <= 1'b1;
      grant_idx           <= 1'b0;
      wr_q                <= 1'b0;
      addr_q              <= '0;
      wdata_q             <= '0;
      wd_cnt              <= '0;
      ack0                <= 1'b0;
      ack1                <= 1'b0;
      err0                <= 1'b0;
      err1                <= 1'b0;
      rdata               <= '0;
      bus.transfer        <= 1'b0;
      bus.PSEL            <= 1'b0;
      bus.READ_WRITE      <= 1'b0;
      bus.apb_write_paddr <= '0;
      bus.apb_read_paddr  <= '0;
      bus.apb_write_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_idx  <= pick_idx;
            last_grant <= pick_idx;
            wr_q       <= pick_idx ? wr1    : wr0;
            addr_q     <= pick_idx ? addr1  : addr0;
            wdata_q    <= pick_idx ? wdata1 : wdata0;
          end
        end
        SETUP: begin
          bus.transfer        <= 1'b1;
          bus.PSEL            <= 1'b1;
          bus.READ_WRITE      <= wr_q ? RW_WRITE : RW_READ;
          bus.apb_write_paddr <= wr_q ? addr_q  : '0;
          bus.apb_read_paddr  <= wr_q ? '0      : addr_q;
          bus.apb_write_data  <= wr_q ? wdata_q : '0;
          wd_cnt              <= '0;
        end
        WAIT: begin
          // Completion takes priority so a strobe on the final watchdog cycle still succeeds.
          if (bus.bridge_done) begin
            bus.transfer <= 1'b0;
            bus.PSEL     <= 1'b0;
            if (!wr_q) rdata <= bus.bridge_rdata;
            ack0 <= ~grant_idx;
            ack1 <= grant_idx;
            err0 <= 1'b0;
            err1 <= 1'b0;
          end else if (wd_expired) begin
            bus.transfer <= 1'b0;
            bus.PSEL     <= 1'b0;
            rdata        <= '0;
            ack0         <= ~grant_idx;
            ack1         <= grant_idx;
            err0         <= ~grant_idx;
            err1         <= grant_idx;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          ack0                <= 1'b0;
          ack1                <= 1'b0;
          err0                <= 1'b0;
          err1                <= 1'b0;
          bus.READ_WRITE      <= 1'b0;
          bus.apb_write_paddr <= '0;
          bus.apb_read_paddr  <= '0;
          bus.apb_write_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level reference model.
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata;

  apb_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .req0    (req0),
    .req1    (req1),
    .wr0     (wr0),
    .wr1     (wr1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .ack0    (ack0),
    .ack1    (ack1),
    .err0    (err0),
    .err1    (err1),
    .rdata   (rdata),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  int            n_chk = 0;
  int            n_fail = 0;
  int            last_m;
  logic [DW-1:0] rdata_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (i == 0) begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic rand_req(input int i);
    new_req(i, 1'($urandom_range(0, 1)), AW'($urandom()), DW'($urandom()));
  endtask

  // Called on the negedge of a cycle in which the DUT is idle with at least one request up.
  // delay >= TO means the bridge never completes.
  task automatic serve(input int delay, input logic [DW-1:0] rd, input bit noise);
    int            w;
    logic          cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    bit            tmo;
    w   = (req0 && req1) ? ((last_m == 0) ? 1 : 0) : (req0 ? 0 : 1);
    cw  = (w == 1) ? wr1 : wr0;
    ca  = (w == 1) ? addr1 : addr0;
    cd  = (w == 1) ? wdata1 : wdata0;
    tmo = (delay >= TO);
    @(negedge PCLK);
    check("setup_quiet", 64'({bus.transfer, ack0, ack1}), '0);
    bus.bridge_done  = 1'($urandom_range(0, 1));
    bus.bridge_rdata = DW'($urandom());
    for (int k = 0; k < TO; k++) begin
      @(negedge PCLK);
      check("xfer_psel_noack", 64'({bus.transfer, bus.PSEL, ack0, ack1}), 64'(4'b1100));
      check("read_write", 64'(bus.READ_WRITE), 64'(cw ? RW_WRITE : RW_READ));
      check("write_paddr", 64'(bus.apb_write_paddr), 64'(cw ? ca : '0));
      check("read_paddr", 64'(bus.apb_read_paddr), 64'(cw ? '0 : ca));
      check("write_data", 64'(bus.apb_write_data), 64'(cw ? cd : '0));
      if (noise) begin
        if ($urandom_range(0, 3) == 0) rand_req(w);
        if (w == 0 && !req1 && $urandom_range(0, 3) == 0) rand_req(1);
        if (w == 1 && !req0 && $urandom_range(0, 3) == 0) rand_req(0);
      end
      bus.bridge_done  = (k == delay);
      bus.bridge_rdata = (k == delay) ? rd : DW'($urandom());
      if (k == delay) break;
    end
    @(negedge PCLK);
    check("resp_xfer_low", 64'({bus.transfer, bus.PSEL}), '0);
    check("ack", 64'({ack1, ack0}), 64'((w == 1) ? 2'b10 : 2'b01));
    check("err", 64'({err1, err0}), 64'(tmo ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00));
    if (tmo) rdata_m = '0;
    else if (!cw) rdata_m = rd;
    check("rdata", 64'(rdata), 64'(rdata_m));
    last_m = w;
    if (w == 0) req0 = 1'b0; else req1 = 1'b0;
    bus.bridge_done = 1'($urandom_range(0, 1));
    @(negedge PCLK);
    check("idle_ctl", 64'({ack0, ack1, err0, err1, bus.transfer, bus.PSEL}), '0);
    check("idle_paddr", {bus.apb_write_paddr, bus.apb_read_paddr}, '0);
    check("idle_wdata", 64'(bus.apb_write_data), '0);
    bus.bridge_done = 1'($urandom_range(0, 1));
  endtask

  int unsigned sel, r;
  int          dly;

  initial begin
    PRESETn = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    bus.bridge_done = 1'b0; bus.bridge_rdata = '0;
    last_m = 1; rdata_m = '0;

    // Reset held with a request pending
    new_req(0, 1'b1, 32'h0000_0004, 32'hA5A5_5A5A);
    repeat (2) @(negedge PCLK);
    check("rst_ctl", 64'({ack0, ack1, err0, err1, bus.transfer, bus.PSEL, bus.READ_WRITE}), '0);
    check("rst_paddr", {bus.apb_write_paddr, bus.apb_read_paddr}, '0);
    check("rst_data", {bus.apb_write_data, rdata}, '0);
    PRESETn = 1'b1;
    serve(2, 32'h0, 1'b0);

    // Read from requester 1
    new_req(1, 1'b0, 32'h0000_0008, 32'h1234_5678);
    serve(1, 32'h0000_00C3, 1'b0);

    // Boundaries: completion on the last watchdog cycle, and immediate completion
    new_req(1, 1'b0, 32'h0000_0010, 32'h0);
    serve(TO - 1, 32'hDEAD_BEEF, 1'b0);
    new_req(0, 1'b0, 32'h0000_0020, 32'h0);
    serve(0, 32'h0BAD_F00D, 1'b0);

    // Stalled slave, then a late completion strobe while idle
    new_req(0, 1'b0, 32'h0000_0030, 32'h0);
    serve(TO, 32'h5555_5555, 1'b0);
    bus.bridge_done = 1'b1;
    @(negedge PCLK);
    bus.bridge_done = 1'b0;
    check("late_done_idle", 64'({ack0, ack1, err0, err1, bus.transfer, bus.PSEL}), '0);
    @(negedge PCLK);
    check("late_done_idle2", 64'({ack0, ack1, bus.transfer}), '0);

    // Reset in the middle of WAIT
    new_req(0, 1'b1, 32'h0000_0040, 32'hCAFE_0001);
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_rst_xfer", 64'(bus.transfer), 64'(1'b1));
    @(negedge PCLK);
    PRESETn = 1'b0;
    @(negedge PCLK);
    check("midrst_ctl", 64'({ack0, ack1, err0, err1, bus.transfer, bus.PSEL, bus.READ_WRITE}), '0);
    check("midrst_paddr", {bus.apb_write_paddr, bus.apb_read_paddr}, '0);
    check("midrst_data", {bus.apb_write_data, rdata}, '0);
    last_m = 1; rdata_m = '0;
    rand_req(1);
    PRESETn = 1'b1;
    serve(1, 32'h7777_0000, 1'b0);

    // Both requesters held: grants must alternate
    if (!req0) rand_req(0);
    if (!req1) rand_req(1);
    for (int i = 0; i < 4; i++) begin
      serve(int'($urandom_range(0, 3)), DW'($urandom()), 1'b0);
      if (!req0) rand_req(0);
      if (!req1) rand_req(1);
    end
    serve(1, DW'($urandom()), 1'b0);
    serve(1, DW'($urandom()), 1'b0);

    // Random traffic
    for (int it = 0; it < 60; it++) begin
      if (!req0 && !req1) begin
        sel = $urandom_range(1, 3);
        if ((sel & 1) != 0) rand_req(0);
        if ((sel & 2) != 0) rand_req(1);
      end else if ($urandom_range(0, 1) == 1) begin
        if (!req0) rand_req(0);
        if (!req1) rand_req(1);
      end
      r   = $urandom_range(0, 7);
      dly = (r == 0) ? TO + 1 : (r == 1) ? TO - 1 : int'($urandom_range(0, 4));
      serve(dly, DW'($urandom()), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
